// File: rtl/color_highlight_pipe.sv
`default_nettype none
// ============================================================================
// Module   : color_highlight_pipe
// Brief    : 3-stage colour-dominance highlighter with frame-synchronous mode
//            switching and a per-frame saturating hit counter.
// Revision : 1.0
// ============================================================================
module color_highlight_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [W-1:0]     in_r,
  input  logic [W-1:0]     in_g,
  input  logic [W-1:0]     in_b,
  input  logic [2:0]       mode_req,
  input  logic             mode_we,
  input  logic [3*W-1:0]   thr_r,
  input  logic [3*W-1:0]   thr_g,
  input  logic [3*W-1:0]   thr_b,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [W-1:0]     out_r,
  output logic [W-1:0]     out_g,
  output logic [W-1:0]     out_b,
  output logic [2:0]       mode_active,
  output logic [CNT_W-1:0] frame_hits,
  output logic             frame_done
);

  localparam logic [2:0] c_mode_red   = 3'd1;
  localparam logic [2:0] c_mode_green = 3'd2;
  localparam logic [2:0] c_mode_blue  = 3'd3;
  localparam logic [2:0] c_mode_any   = 3'd4;
  localparam logic [2:0] c_mode_mask  = 3'd5;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = 1;

  function automatic logic [3*W-1:0] zext(input logic [W-1:0] x);
    return {{(2*W){1'b0}}, x};
  endfunction

  // ---------------------------------------------------------------- mode regs
  logic [2:0] mode_pending_q, mode_pending_d;
  logic [2:0] mode_active_q,  mode_active_d;

  // A write coinciding with an accepted sop bypasses the pending register.
  always_comb begin
    mode_pending_d = mode_we ? mode_req : mode_pending_q;
    mode_active_d  = mode_active_q;
    if (in_valid && in_sop) begin
      mode_active_d = mode_we ? mode_req : mode_pending_q;
    end
  end

  // ---------------------------------------------------------------- stage 1
  // Channel index 0 = red, 1 = green, 2 = blue throughout.
  logic             v1_q, v1_d, sop1_q, sop1_d, eop1_q, eop1_d;
  logic [2:0][W-1:0] pix1_q, pix1_d;
  logic [2:0][W-1:0] da1_q, da1_d;
  logic [2:0][W-1:0] db1_q, db1_d;
  logic [2:0]        ok1_q, ok1_d;
  logic [W-1:0]      gs1_q, gs1_d;
  logic [2:0]        mode1_q, mode1_d;
  logic [W+1:0]      gs_sum;

  always_comb begin
    v1_d    = in_valid;
    sop1_d  = in_valid & in_sop;
    eop1_d  = in_valid & in_eop;
    pix1_d  = pix1_q;
    da1_d   = da1_q;
    db1_d   = db1_q;
    ok1_d   = ok1_q;
    gs1_d   = gs1_q;
    mode1_d = mode1_q;
    gs_sum  = {2'b00, in_r} + {1'b0, in_g, 1'b0} + {2'b00, in_b};
    if (in_valid) begin
      pix1_d   = {in_b, in_g, in_r};
      gs1_d    = W'(gs_sum >> 2);
      mode1_d  = mode_active_d;
      da1_d[0] = in_r - in_g;
      db1_d[0] = in_r - in_b;
      ok1_d[0] = (in_r > in_g) && (in_r > in_b);
      da1_d[1] = in_g - in_r;
      db1_d[1] = in_g - in_b;
      ok1_d[1] = (in_g > in_r) && (in_g > in_b);
      da1_d[2] = in_b - in_r;
      db1_d[2] = in_b - in_g;
      ok1_d[2] = (in_b > in_r) && (in_b > in_g);
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic                v2_q, v2_d, sop2_q, sop2_d, eop2_q, eop2_d;
  logic [2:0][W-1:0]   pix2_q, pix2_d;
  logic [2:0][3*W-1:0] score2_q, score2_d;
  logic [W-1:0]        gs2_q, gs2_d;
  logic [2:0]          mode2_q, mode2_d;

  // Differences are only meaningful when the ordering holds; otherwise score 0.
  always_comb begin
    v2_d     = v1_q;
    sop2_d   = sop1_q;
    eop2_d   = eop1_q;
    pix2_d   = pix2_q;
    score2_d = score2_q;
    gs2_d    = gs2_q;
    mode2_d  = mode2_q;
    if (v1_q) begin
      pix2_d  = pix1_q;
      gs2_d   = gs1_q;
      mode2_d = mode1_q;
      for (int c = 0; c < 3; c++) begin
        score2_d[c] = ok1_q[c] ? zext(pix1_q[c]) * zext(da1_q[c]) * zext(db1_q[c])
                               : '0;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic                v3_q, v3_d, sop3_q, sop3_d, eop3_q, eop3_d;
  logic [2:0][W-1:0]   out_pix_q, out_pix_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    frame_hits_q, frame_hits_d;
  logic                frame_done_q, frame_done_d;
  logic [2:0][3*W-1:0] thr;
  logic [2:0]          ch_hit;
  logic                px_hit;

  assign thr = {thr_b, thr_g, thr_r};

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      ch_hit[c] = score2_q[c] > thr[c];
    end
    case (mode2_q)
      c_mode_red:               px_hit = ch_hit[0];
      c_mode_green:             px_hit = ch_hit[1];
      c_mode_blue:              px_hit = ch_hit[2];
      c_mode_any, c_mode_mask:  px_hit = |ch_hit;
      default:                  px_hit = 1'b0;
    endcase
  end

  always_comb begin
    v3_d         = v2_q;
    sop3_d       = sop2_q;
    eop3_d       = eop2_q;
    out_pix_d    = out_pix_q;
    cnt_d        = cnt_q;
    frame_hits_d = frame_hits_q;
    frame_done_d = v2_q & eop2_q;
    if (v2_q) begin
      case (mode2_q)
        c_mode_red, c_mode_green, c_mode_blue, c_mode_any:
          out_pix_d = px_hit ? pix2_q : {3{gs2_q}};
        c_mode_mask:
          out_pix_d = px_hit ? '1 : '0;
        default:
          out_pix_d = pix2_q;
      endcase
      // sop restarts the frame count; the eop pixel is counted before latching.
      if (sop2_q) begin
        cnt_d = px_hit ? c_cnt_one : '0;
      end else if (px_hit && (cnt_q != c_cnt_max)) begin
        cnt_d = cnt_q + c_cnt_one;
      end
      if (eop2_q) begin
        frame_hits_d = cnt_d;
      end
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_pending_q <= '0;
      mode_active_q  <= '0;
      v1_q           <= 1'b0;
      sop1_q         <= 1'b0;
      eop1_q         <= 1'b0;
      pix1_q         <= '0;
      da1_q          <= '0;
      db1_q          <= '0;
      ok1_q          <= '0;
      gs1_q          <= '0;
      mode1_q        <= '0;
      v2_q           <= 1'b0;
      sop2_q         <= 1'b0;
      eop2_q         <= 1'b0;
      pix2_q         <= '0;
      score2_q       <= '0;
      gs2_q          <= '0;
      mode2_q        <= '0;
      v3_q           <= 1'b0;
      sop3_q         <= 1'b0;
      eop3_q         <= 1'b0;
      out_pix_q      <= '0;
      cnt_q          <= '0;
      frame_hits_q   <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      mode_pending_q <= mode_pending_d;
      mode_active_q  <= mode_active_d;
      v1_q           <= v1_d;
      sop1_q         <= sop1_d;
      eop1_q         <= eop1_d;
      pix1_q         <= pix1_d;
      da1_q          <= da1_d;
      db1_q          <= db1_d;
      ok1_q          <= ok1_d;
      gs1_q          <= gs1_d;
      mode1_q        <= mode1_d;
      v2_q           <= v2_d;
      sop2_q         <= sop2_d;
      eop2_q         <= eop2_d;
      pix2_q         <= pix2_d;
      score2_q       <= score2_d;
      gs2_q          <= gs2_d;
      mode2_q        <= mode2_d;
      v3_q           <= v3_d;
      sop3_q         <= sop3_d;
      eop3_q         <= eop3_d;
      out_pix_q      <= out_pix_d;
      cnt_q          <= cnt_d;
      frame_hits_q   <= frame_hits_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign out_valid   = v3_q;
  assign out_sop     = sop3_q;
  assign out_eop     = eop3_q;
  assign out_r       = out_pix_q[0];
  assign out_g       = out_pix_q[1];
  assign out_b       = out_pix_q[2];
  assign mode_active = mode_active_q;
  assign frame_hits  = frame_hits_q;
  assign frame_done  = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_color_highlight_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_highlight_pipe
// Brief    : Directed plus randomized bench for color_highlight_pipe against a
//            pixel-level reference model.
// Revision : 1.0
// ============================================================================
module tb_color_highlight_pipe;
  localparam int W     = 8;
  localparam int CNT_W = 5;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, in_valid, in_sop, in_eop, mode_we;
  logic [W-1:0]     in_r, in_g, in_b;
  logic [2:0]       mode_req;
  logic [3*W-1:0]   thr_r, thr_g, thr_b;
  logic             out_valid, out_sop, out_eop, frame_done;
  logic [W-1:0]     out_r, out_g, out_b;
  logic [2:0]       mode_active;
  logic [CNT_W-1:0] frame_hits;

  color_highlight_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .mode_req(mode_req), .mode_we(mode_we),
    .thr_r(thr_r), .thr_g(thr_g), .thr_b(thr_b),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .mode_active(mode_active),
    .frame_hits(frame_hits), .frame_done(frame_done)
  );

  typedef struct packed {
    logic v, s, e;
    logic [7:0] r, g, b;
    logic done;
    logic [CNT_W-1:0] hits;
  } rec_t;

  typedef struct packed {
    logic s, e;
    logic [7:0] r, g, b;
  } cap_t;

  rec_t exp_q[$];
  cap_t cap_q[$];
  int   done_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   m_pend = 0, m_act = 0, m_cnt = 0, m_hits = 0;
  int   lr = 0, lg = 0, lb = 0;

  // ------------------------------------------------------------ reference model
  function automatic longint score(input int p, input int q, input int r);
    if (p > q && p > r) return longint'(p) * longint'(p - q) * longint'(p - r);
    return 0;
  endfunction

  function automatic void model_pixel(input int mode, input int r, input int g, input int b,
                                      output int orr, output int og, output int ob,
                                      output bit hit);
    bit hr, hg, hb;
    int gs;
    hr = score(r, g, b) > longint'(thr_r);
    hg = score(g, r, b) > longint'(thr_g);
    hb = score(b, r, g) > longint'(thr_b);
    gs = (r + 2 * g + b) / 4;
    case (mode)
      1: hit = hr;
      2: hit = hg;
      3: hit = hb;
      4, 5: hit = hr | hg | hb;
      default: hit = 1'b0;
    endcase
    if (mode == 0 || mode >= 6) begin
      orr = r; og = g; ob = b;
    end else if (mode == 5) begin
      orr = hit ? 255 : 0; og = orr; ob = orr;
    end else if (hit) begin
      orr = r; og = g; ob = b;
    end else begin
      orr = gs; og = gs; ob = gs;
    end
  endfunction

  always @(posedge clk) begin : model
    rec_t rec;
    int orr, og, ob;
    bit hit;
    if (rst) begin
      m_pend = 0; m_act = 0; m_cnt = 0; m_hits = 0;
      lr = 0; lg = 0; lb = 0;
      exp_q.delete();
      repeat (3) exp_q.push_back('0);
    end else begin
      if (in_valid && in_sop) m_act = mode_we ? int'(mode_req) : m_pend;
      if (mode_we) m_pend = int'(mode_req);
      if (in_valid) begin
        model_pixel(m_act, int'(in_r), int'(in_g), int'(in_b), orr, og, ob, hit);
        if (in_sop) m_cnt = int'(hit);
        else if (hit && m_cnt < MAXC) m_cnt = m_cnt + 1;
        if (in_eop) m_hits = m_cnt;
        lr = orr; lg = og; lb = ob;
      end
      rec.v = in_valid;
      rec.s = in_valid & in_sop;
      rec.e = in_valid & in_eop;
      rec.r = lr[7:0];
      rec.g = lg[7:0];
      rec.b = lb[7:0];
      rec.done = in_valid & in_eop;
      rec.hits = m_hits[CNT_W-1:0];
      exp_q.push_back(rec);
      while (exp_q.size() > 3) void'(exp_q.pop_front());
    end
  end

  // ------------------------------------------------------------ per-cycle compare
  always @(negedge clk) begin : compare
    rec_t e, a;
    if (exp_q.size() == 3) begin
      e = exp_q[0];
      a = {out_valid, out_sop, out_eop, out_r, out_g, out_b, frame_done, frame_hits};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL stream t=%0t got v=%0b s=%0b e=%0b rgb=%0d,%0d,%0d done=%0b hits=%0d expected v=%0b s=%0b e=%0b rgb=%0d,%0d,%0d done=%0b hits=%0d",
                 $time, a.v, a.s, a.e, a.r, a.g, a.b, a.done, a.hits,
                 e.v, e.s, e.e, e.r, e.g, e.b, e.done, e.hits);
      end
      n_cmp++;
      if (mode_active !== m_act[2:0]) begin
        n_fail++;
        $display("FAIL mode_active t=%0t got %0d expected %0d", $time, mode_active, m_act);
      end
    end
    if (out_valid === 1'b1) cap_q.push_back({out_sop, out_eop, out_r, out_g, out_b});
    if (frame_done === 1'b1) done_q.push_back(int'(frame_hits));
  end

  // ------------------------------------------------------------ helpers
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_pix(input string name, input int idx, input int r, input int g, input int b);
    longint exp_v;
    exp_v = (r << 16) | (g << 8) | b;
    if (cap_q.size() > idx) chk(name, {cap_q[idx].r, cap_q[idx].g, cap_q[idx].b}, exp_v);
    else chk(name, -1, exp_v);
  endtask

  task automatic chk_done(input string name, input int idx, input int exp_v);
    if (done_q.size() > idx) chk(name, done_q[idx], exp_v);
    else chk(name, -1, exp_v);
  endtask

  task automatic drive(input bit v, input bit s, input bit e,
                       input int r, input int g, input int b,
                       input bit we = 1'b0, input int mreq = 0);
    @(negedge clk);
    in_valid = v; in_sop = s; in_eop = e;
    in_r = r[7:0]; in_g = g[7:0]; in_b = b[7:0];
    mode_we = we; mode_req = mreq[2:0];
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic set_mode(input int m);
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, m);
  endtask

  task automatic clear_caps();
    cap_q.delete();
    done_q.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ stimulus
  initial begin : main
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; mode_req = '0; mode_we = 1'b0;
    thr_r = 24'd1_000_000; thr_g = 24'd1_000_000; thr_b = 24'd1_000_000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_rgb", {out_r, out_g, out_b}, 0);
    chk("reset frame_hits", frame_hits, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset mode_active", mode_active, 0);

    // Red highlight: hit, equal-grey, and non-dominant red.
    clear_caps();
    set_mode(1);
    drive(1, 1, 1, 200, 50, 40);
    drive(1, 1, 1, 100, 100, 100);
    drive(1, 1, 1, 120, 200, 40);
    idle(5);
    chk("red n_out", cap_q.size(), 3);
    chk_pix("red hit", 0, 200, 50, 40);
    chk_pix("red grey equal", 1, 100, 100, 100);
    chk_pix("red grey miss", 2, 140, 140, 140);
    chk_done("red hit frame count", 0, 1);
    chk("red mode_active", mode_active, 1);

    // Mid-frame mode write must wait for the next sop.
    clear_caps();
    drive(1, 1, 0, 200, 50, 40);
    drive(1, 0, 0, 200, 50, 40, 1'b1, 2);
    drive(1, 0, 1, 200, 50, 40);
    chk("mode held mid-frame", mode_active, 1);
    drive(1, 1, 1, 50, 200, 40);
    idle(1);
    chk("mode switched at sop", mode_active, 2);
    idle(4);
    chk_pix("switch mid pixel red", 1, 200, 50, 40);
    chk_pix("switch eop pixel red", 2, 200, 50, 40);
    chk_pix("switch green sop", 3, 50, 200, 40);

    // Counter: 10-pixel frame with 4 red hits, then a 1-pixel hit frame.
    clear_caps();
    set_mode(1);
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 3 || i == 5 || i == 9)
        drive(1, i == 0, i == 9, 200, 50, 40);
      else
        drive(1, i == 0, i == 9, 10, 10, 10);
    end
    drive(1, 1, 1, 200, 50, 40);
    idle(5);
    chk("count frames", done_q.size(), 2);
    chk_done("count 10px frame", 0, 4);
    chk_done("count 1px frame", 1, 1);
    chk("count last eop flagged", (cap_q.size() == 11) ? cap_q[10].e : 1'b0, 1);

    // Saturation of the frame counter in highlight-any mode.
    clear_caps();
    set_mode(4);
    for (int i = 0; i < 40; i++) drive(1, i == 0, i == 39, 200, 50, 40);
    idle(5);
    chk_done("count saturates", 0, MAXC);

    // Mask-any with zero green threshold, then mode 6 pass-through.
    thr_g = '0;
    clear_caps();
    set_mode(5);
    drive(1, 1, 0, 0, 255, 0);
    drive(1, 0, 1, 10, 10, 10);
    set_mode(6);
    drive(1, 1, 1, 0, 255, 0);
    idle(5);
    chk_pix("mask hit", 0, 255, 255, 255);
    chk_pix("mask miss", 1, 0, 0, 0);
    chk_pix("mode6 pass", 2, 0, 255, 0);
    chk_done("mask frame count", 0, 1);
    chk("mode6 frame_hits", frame_hits, 0);

    // Reset with two pixels in flight.
    set_mode(1);
    drive(1, 1, 1, 200, 50, 40);
    idle(5);
    chk("pre-reset frame_hits", frame_hits, 1);
    clear_caps();
    drive(1, 1, 0, 200, 50, 40);
    drive(1, 0, 0, 200, 50, 40);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; mode_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    chk("reset drops in-flight", cap_q.size(), 0);
    chk("reset frame_hits", frame_hits, 0);
    chk("reset mode_active", mode_active, 0);

    // Randomized traffic checked by the per-cycle compare.
    for (int bt = 0; bt < 6; bt++) begin
      idle(6);
      thr_r = 24'($urandom_range(0, 3_000_000));
      thr_g = 24'($urandom_range(0, 3_000_000));
      thr_b = (bt == 1) ? 24'd0 : 24'($urandom_range(0, 3_000_000));
      for (int i = 0; i < 400; i++) begin
        int px[3];
        int k;
        if (bt == 3 && i == 200) begin
          @(negedge clk);
          rst = 1'b1; in_valid = 1'b0; mode_we = 1'b0;
          @(negedge clk);
          rst = 1'b0;
        end
        k = $urandom_range(0, 3);
        for (int c = 0; c < 3; c++) px[c] = $urandom_range(0, 255);
        if (k < 3) begin
          for (int c = 0; c < 3; c++) px[c] = $urandom_range(0, 120);
          px[k] = $urandom_range(150, 255);
        end
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
              px[0], px[1], px[2], $urandom_range(0, 11) == 0, $urandom_range(0, 7));
      end
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
